demux_case: RTL and testbench

DEMUX_CASE -- requirements
Module: demux_case

---
 rtl/demux_case.sv | 72 +++++++
 tb/tb_demux_case.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/demux_case.sv
// 1-to-4 demultiplexer with registered copies of the output and select,
// plus one saturating event counter per channel.
module demux_case #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             I,
    input  logic [1:0]       S,
    input  logic             clr,
    output logic [3:0]       Y,
    output logic [3:0]       Y_q,
    output logic [1:0]       S_q,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt3
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Decoding {S,I} together sends any X/Z on either input to the all-zero default.
    always_comb begin
        Y = 4'b0000;
        case ({S, I})
            3'b001:  Y = 4'b0001;
            3'b011:  Y = 4'b0010;
            3'b101:  Y = 4'b0100;
            3'b111:  Y = 4'b1000;
            default: Y = 4'b0000;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = cnt_q[k];
        end
        if (clr) begin
            for (int k = 0; k < 4; k++) begin
                cnt_d[k] = '0;
            end
        end else if (I && (cnt_q[S] != CNT_MAX)) begin
            cnt_d[S] = cnt_q[S] + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Y_q <= 4'b0000;
            S_q <= 2'b00;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            Y_q <= Y;
            S_q <= S;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_demux_case.sv
// Bench for demux_case: directed scenarios followed by random traffic,
// checked against a behavioural model on a wide and a 2-bit-counter instance.
module tb_demux_case;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       I;
    logic [1:0] S;
    logic       clr;

    logic [3:0] w_y, w_yq, n_y, n_yq;
    logic [1:0] w_sq, n_sq;
    logic [7:0] w_cnt [4];
    logic [1:0] n_cnt [4];

    int checks;
    int errors;

    int         m_wc [4];
    int         m_nc [4];
    logic [3:0] m_yq;
    logic [1:0] m_sq;

    demux_case #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .I(I), .S(S), .clr(clr),
        .Y(w_y), .Y_q(w_yq), .S_q(w_sq),
        .cnt0(w_cnt[0]), .cnt1(w_cnt[1]), .cnt2(w_cnt[2]), .cnt3(w_cnt[3])
    );

    demux_case #(.CNT_W(2)) dut_n (
        .clk(clk), .rst_n(rst_n), .I(I), .S(S), .clr(clr),
        .Y(n_y), .Y_q(n_yq), .S_q(n_sq),
        .cnt0(n_cnt[0]), .cnt1(n_cnt[1]), .cnt2(n_cnt[2]), .cnt3(n_cnt[3])
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [3:0] ycomb(input logic [1:0] s, input logic i);
        return i ? 4'(4'd1 << s) : 4'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_yq = 4'b0000;
        m_sq = 2'b00;
        for (int k = 0; k < 4; k++) begin
            m_wc[k] = 0;
            m_nc[k] = 0;
        end
    endtask

    // Model of what the registers should hold after the coming edge.
    task automatic model_edge();
        m_yq = ycomb(S, I);
        m_sq = S;
        if (clr) begin
            for (int k = 0; k < 4; k++) begin
                m_wc[k] = 0;
                m_nc[k] = 0;
            end
        end else if (I) begin
            m_wc[S] = (m_wc[S] + 1 > 255) ? 255 : m_wc[S] + 1;
            m_nc[S] = (m_nc[S] + 1 > 3) ? 3 : m_nc[S] + 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_Y"}, 32'(w_y), 32'(ycomb(S, I)));
        check({tag, "_Yn"}, 32'(n_y), 32'(ycomb(S, I)));
        check({tag, "_Yq"}, 32'(w_yq), 32'(m_yq));
        check({tag, "_Yqn"}, 32'(n_yq), 32'(m_yq));
        check({tag, "_Sq"}, 32'(w_sq), 32'(m_sq));
        check({tag, "_Sqn"}, 32'(n_sq), 32'(m_sq));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("%s_cnt%0d", tag, k), 32'(w_cnt[k]), 32'(m_wc[k]));
            check($sformatf("%s_ncnt%0d", tag, k), 32'(n_cnt[k]), 32'(m_nc[k]));
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic comb(input logic [1:0] s, input logic i, input logic [3:0] exp);
        S = s;
        I = i;
        #20;
        check($sformatf("comb_S%0d_I%0d", s, i), 32'(w_y), 32'(exp));
        check("comb_Yq_idle", 32'(w_yq), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst_n  = 1'b0;
        clr    = 1'b0;
        I      = 1'b0;
        S      = 2'b00;
        model_reset();
        #1;
        check_all("reset");

        comb(2'b00, 1'b1, 4'b0001);
        comb(2'b01, 1'b1, 4'b0010);
        comb(2'b10, 1'b1, 4'b0100);
        comb(2'b11, 1'b0, 4'b0000);
        comb(2'b11, 1'b1, 4'b1000);
        comb(2'b11, 1'b0, 4'b0000);

        S = 2'b00;
        I = 1'b0;
        #2 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        step("idle");

        // One-cycle latency of the registered outputs.
        S = 2'b10;
        I = 1'b1;
        #1;
        check("Yq_before_edge", 32'(w_yq), 32'd0);
        check("Sq_before_edge", 32'(w_sq), 32'd0);
        step("reg");
        check("Yq_after_edge", 32'(w_yq), 32'h4);
        check("Sq_after_edge", 32'(w_sq), 32'h2);

        clr = 1'b1;
        step("clr0");
        clr = 1'b0;
        S = 2'b01;
        I = 1'b1;
        repeat (3) step("cnt1_inc");
        I = 1'b0;
        step("cnt1_hold");
        check("count_cnt1", 32'(w_cnt[1]), 32'd3);
        check("count_cnt0", 32'(w_cnt[0]), 32'd0);
        check("count_cnt2", 32'(w_cnt[2]), 32'd0);
        check("count_cnt3", 32'(w_cnt[3]), 32'd0);

        // Saturation on the 2-bit instance, then clear beating an increment.
        clr = 1'b1;
        step("clr1");
        clr = 1'b0;
        S = 2'b00;
        I = 1'b1;
        repeat (5) step("sat");
        check("sat_ncnt0", 32'(n_cnt[0]), 32'd3);
        check("sat_wcnt0", 32'(w_cnt[0]), 32'd5);
        clr = 1'b1;
        step("clr_prio");
        check("clr_prio_ncnt0", 32'(n_cnt[0]), 32'd0);
        check("clr_prio_wcnt0", 32'(w_cnt[0]), 32'd0);
        check("clr_keeps_Yq", 32'(w_yq), 32'h1);
        clr = 1'b0;

        S = 2'b10;
        I = 1'b1;
        repeat (5) step("pre_rst");
        check("pre_rst_cnt2", 32'(w_cnt[2]), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_cnt2", 32'(w_cnt[2]), 32'd0);
        check("arst_Yq", 32'(w_yq), 32'd0);
        check("arst_Y", 32'(w_y), 32'h4);
        check_all("arst");
        #1 rst_n = 1'b1;
        step("post_rst");
        check("post_rst_cnt2", 32'(w_cnt[2]), 32'd1);
        check("post_rst_Yq", 32'(w_yq), 32'h4);

        for (int n = 0; n < 300; n++) begin
            S   = 2'($urandom_range(0, 3));
            I   = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 31) == 0);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
